// File: rtl/int_ack_seq.sv
// Interrupt acknowledge sequencer: INTA handshake, vector capture, then IP/CS fetch from the vector table.
// Define INTA_NMI_EN to add the iNmi port and rising-edge NMI servicing through vector 2.
module int_ack_seq #(
  parameter int unsigned TIMEOUT      = 4,
  parameter logic [7:0]  SPURIOUS_VEC = 8'h0F
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iIntr,
  input  logic        iIf,
  input  logic        iBoundary,
  output logic        oIntAck,
  input  logic        iSel,
  input  logic [7:0]  iData,
  output logic        oMemReq,
  output logic [19:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [15:0] iMemData,
  output logic        oBusy,
  output logic        oVecValid,
  output logic [7:0]  oVec,
  output logic [15:0] oIp,
  output logic [15:0] oCs
`ifdef INTA_NMI_EN
  ,
  input  logic        iNmi
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACK     = 3'd1;
  localparam logic [2:0] WAITVEC = 3'd2;
  localparam logic [2:0] RDIP    = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;
  localparam logic [2:0] RDCS    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  // Counter value seen in the final WAITVEC cycle before the spurious vector is forced.
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);
  localparam logic [7:0] NMI_VEC      = 8'h02;

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [3:0]  timeoutCnt;
  logic [3:0]  timeoutCntNext;
  logic [7:0]  vecReg;
  logic [7:0]  vecNext;
  logic [15:0] ipReg;
  logic [15:0] ipNext;
  logic [15:0] csReg;
  logic [15:0] csNext;
  logic [19:0] addrNext;

`ifdef INTA_NMI_EN
  logic nmiPrev;
  logic nmiPend;
  logic nmiValid;
  logic nmiTake;

  // An edge in the current IDLE cycle counts immediately, so a fresh NMI beats a concurrent INTR.
  assign nmiValid = nmiPend | (iNmi & ~nmiPrev);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      nmiPrev <= 1'b0;
      nmiPend <= 1'b0;
    end else begin
      nmiPrev <= iNmi;
      nmiPend <= nmiValid & ~nmiTake;
    end
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    stateNext      = state;
    timeoutCntNext = timeoutCnt;
    vecNext        = vecReg;
    ipNext         = ipReg;
    csNext         = csReg;
`ifdef INTA_NMI_EN
    nmiTake        = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef INTA_NMI_EN
        if (nmiValid && iBoundary) begin
          vecNext   = NMI_VEC;
          nmiTake   = 1'b1;
          stateNext = RDIP;
        end else
`endif
        if (iIntr && iIf && iBoundary) begin
          stateNext = ACK;
        end
      end
      ACK: begin
        timeoutCntNext = 4'd0;
        stateNext      = WAITVEC;
      end
      WAITVEC: begin
        // A real vector arriving in the last timeout cycle still takes precedence.
        if (iSel) begin
          vecNext   = iData;
          stateNext = RDIP;
        end else if (timeoutCnt == TIMEOUT_LAST) begin
          vecNext   = SPURIOUS_VEC;
          stateNext = RDIP;
        end else begin
          timeoutCntNext = timeoutCnt + 4'd1;
        end
      end
      RDIP: begin
        if (iMemAck) begin
          ipNext    = iMemData;
          stateNext = GAP;
        end
      end
      GAP: begin
        stateNext = RDCS;
      end
      RDCS: begin
        if (iMemAck) begin
          csNext    = iMemData;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Address follows the state being entered so it is registered alongside oMemReq.
  always_comb begin
    addrNext = oMemAddr;
    if (stateNext == RDIP) begin
      addrNext = {10'b0, vecNext, 2'b00};
    end else if (stateNext == RDCS) begin
      addrNext = {10'b0, vecReg, 2'b10};
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      timeoutCnt <= 4'd0;
      vecReg     <= 8'h00;
      ipReg      <= 16'h0000;
      csReg      <= 16'h0000;
      oIntAck    <= 1'b0;
      oMemReq    <= 1'b0;
      oMemAddr   <= 20'h00000;
      oBusy      <= 1'b0;
      oVecValid  <= 1'b0;
      oVec       <= 8'h00;
      oIp        <= 16'h0000;
      oCs        <= 16'h0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= stateNext;
      timeoutCnt <= timeoutCntNext;
      vecReg     <= vecNext;
      ipReg      <= ipNext;
      csReg      <= csNext;
      oIntAck    <= (stateNext == ACK);
      oMemReq    <= (stateNext == RDIP) || (stateNext == RDCS);
      oMemAddr   <= addrNext;
      oBusy      <= (stateNext != IDLE);
      oVecValid  <= (stateNext == DONE);
      // Visible results change only together with the valid pulse.
      if (stateNext == DONE) begin
        oVec <= vecReg;
        oIp  <= ipReg;
        oCs  <= csNext;
      end
    end
  end

endmodule

// File: doc/int_ack_seq.md
# int_ack_seq

CPU-side interrupt acknowledge sequencer for the 8088-compatible core; the initiator for the chipset interrupt controller. At an instruction boundary with interrupts enabled and a pending request, it issues the acknowledge pulse, captures the vector byte from the bus, then fetches the IP and CS words from the interrupt vector table. It hands the new CS:IP to the execution unit.

## Interface
- TIMEOUT, 4: cycles after the ack pulse to wait for the controller to drive the bus (1..15)
- SPURIOUS_VEC, 8'h0F: vector used when the controller never drives the bus
- iClk  in  1  system clock
- iRst  in  1  reset; synchronous, active-high
- iIntr  in  1  interrupt request from the controller (level)
- iIf  in  1  CPU interrupt-enable flag
- iBoundary  in  1  CPU is at an instruction boundary this cycle
- oIntAck  out  1  one-cycle acknowledge pulse to the controller
- iSel  in  1  controller is driving iData this cycle
- iData  in  8  vector byte from the controller
- oMemReq  out  1  memory read request
- oMemAddr  out  20  physical word address of the read
- iMemAck  in  1  read complete; iMemData valid this cycle
- iMemData  in  16  read data, little-endian word
- oBusy  out  1  sequencer owns the bus; CPU holds off its own cycles
- oVecValid  out  1  one-cycle pulse: oVec, oIp and oCs are valid
- oVec  out  8  vector serviced
- oIp  out  16  new instruction pointer
- oCs  out  16  new code segment
- iNmi  in  1  non-maskable interrupt, rising-edge sensitive (present only with INTA_NMI_EN)

## Operation
- States: IDLE, ACK, WAITVEC, RDIP, GAP, RDCS, DONE.
- IDLE: if iIntr & iIf & iBoundary, go to ACK. Otherwise stay.
- ACK: oIntAck is high for exactly this one cycle. Clear the timeout counter. Go to WAITVEC.
- WAITVEC: when iSel is high, latch iData into oVec and go to RDIP.
  - The counter increments every cycle iSel is low.
  - After TIMEOUT cycles without iSel, latch SPURIOUS_VEC and go to RDIP.
  - iSel in the same cycle as the last timeout cycle wins; the real vector is used.
- RDIP: oMemReq is high and oMemAddr = {10'b0, oVec, 2'b00}.
  - Hold both stable until iMemAck.
  - On iMemAck, latch iMemData into the IP register and go to GAP.
- GAP: oMemReq is low for exactly one cycle. Go to RDCS.
- RDCS: as RDIP, with oMemAddr = {10'b0, oVec, 2'b10}. On iMemAck, latch the CS register and go to DONE.
- DONE: oVecValid is high for one cycle. Go to IDLE.
- oIp, oCs and oVec hold their values until the next DONE.
- oBusy = (state != IDLE).
- iIntr dropping after IDLE has no effect; the sequence runs to completion.
- iBoundary and iIf are ignored outside IDLE.
- iMemAck outside RDIP/RDCS is ignored.
- iSel outside WAITVEC is ignored.
- Reset mid-sequence: the state returns to IDLE at that edge, and every output goes to its reset value from the next cycle. The memory request is abandoned; there is no completion.
- Reset values: oIntAck=0, oMemReq=0, oMemAddr=0, oBusy=0, oVecValid=0, oVec=0, oIp=0, oCs=0.

## Timing
- Condition sampled in IDLE at edge E0 (end of cycle T).
  - oIntAck is high in T+1.
  - The controller asserts iSel in T+2, and the vector is captured at the end of T+2.
  - oMemReq is high from T+3.
- With zero-wait memory (iMemAck in the first request cycle): IP read in T+3, GAP in T+4, CS read in T+5, oVecValid in T+6. The minimum latency is 6 cycles.
- Each memory wait cycle adds one cycle of latency.
- The timeout path adds TIMEOUT−1 cycles versus a response in T+2.
- All outputs are registered.

## Configuration
- INTA_NMI_EN defined:
  - The iNmi port exists. A rising edge sets an NMI-pending flag in any state; the flag clears on entry to RDIP for an NMI.
  - In IDLE, pending NMI & iBoundary skips ACK/WAITVEC: oVec=8'h02, go directly to RDIP. iIf is ignored.
  - NMI has priority over iIntr when both are valid in the same IDLE cycle.
  - An edge arriving during a sequence is serviced after DONE.
- INTA_NMI_EN undefined: there is no iNmi port and no NMI logic. Only maskable requests are serviced.

## Test plan
- Basic ack: iIntr=1, iIf=1, iBoundary=1; controller drives iSel with iData=8'h08 in T+2; memory returns 16'h1234 at 0x00020 and 16'hF000 at 0x00022, zero-wait. Required: oIntAck only in T+1, oVecValid in T+6, oVec=08, oIp=1234, oCs=F000.
- Masking: iIntr=1, iIf=0 for 20 cycles. Required: oIntAck, oMemReq and oBusy remain 0.
- Spurious: ack issued, iSel never asserted. Required: after 4 wait cycles, oMemAddr=0x0003C then 0x0003E; oVec=0F.
- Memory wait states: iMemAck delayed 3 cycles on each read. Required: oMemAddr stable while oMemReq is high; exactly one GAP cycle with oMemReq=0; oVecValid in T+12.
- Reset mid-sequence: assert iRst during RDCS. Required: next cycle oMemReq=0, oBusy=0, oVecValid never pulses, oIp/oCs/oVec=0.
- NMI (INTA_NMI_EN): iNmi rising edge together with iIntr=1 at a boundary. Required: no oIntAck, reads at 0x00008/0x0000A, oVec=02. The INTR sequence (with oIntAck) follows after DONE.
